uart_rx: RTL and testbench

Asynchronous serial receiver: the receive-side counterpart of the team's `uart_tx`, sharing its parameter set and frame format (start, LSB-first data, optional parity, stop bits). It synchronises the raw line and detects the start edge. Each bit is sampled at its centre using a baud-rate counter derived from the system clock. Each completed frame is presented on the user side as a single-cycle valid pulse with parity and framing status. It sits between the board RX pin and user logic; there is no backpressure, because a UART line cannot be stalled.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: parity-mode codes, FSM encoding
// and the parity-error helper.
package uart_rx_pkg;

  localparam int CHECK_NONE = 0;
  localparam int CHECK_ODD  = 1;
  localparam int CHECK_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // ones_odd is the XOR-reduction of data plus the received parity bit.
  function automatic logic parity_error(input int mode, input logic ones_odd);
    case (mode)
      CHECK_ODD:  return ~ones_odd;
      CHECK_EVEN: return ones_odd;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw RX pin plus a history flop for
// falling-edge detection. All flops reset to the idle-high line level.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = i_rx;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_rx_s = sync_q;
  assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-sampled start/data/parity/stop bits, one-cycle valid
// pulse per completed frame with parity and framing status.
//
// state  | meaning
// IDLE   | waiting for a 1->0 transition on the synchronised line
// START  | half a bit into the start bit; a high sample means glitch
// DATA   | sampling data bits LSB-first, one per bit period
// PARITY | sampling the parity bit
// STOP   | sampling stop bits; frame result is registered after the last
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_user_rx_parity_err,
  output logic                         o_user_rx_frame_err,
  output logic                         o_user_rx_busy
);

  localparam int DIV  = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int HALF = DIV / 2;
  localparam int W    = P_UART_DATA_WIDTH;

  if (DIV < 4 || DIV > 65535) begin : g_bad_div
    $error("uart_rx: clock/baud ratio %0d outside 4..65535", DIV);
  end

  // Baud timer counts down and fires at zero, so loading N-1 gives N cycles.
  localparam logic [15:0] HALF_M1   = 16'(HALF - 1);
  localparam logic [15:0] DIV_M1    = 16'(DIV - 1);
  localparam logic [3:0]  LAST_DATA = 4'(W - 1);
  localparam logic [3:0]  LAST_STOP = 4'(P_UART_STOP_WIDTH - 1);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rx    (i_uart_rx),
    .o_rx_s  (rx_s),
    .o_fall  (fall)
  );

  rx_state_e      state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           par_q, par_d;
  logic           ferr_acc_q, ferr_acc_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           busy_q, busy_d;
  logic           baud_tc;
  logic           stop_err;

  assign baud_tc  = (baud_q == 16'd0);
  assign stop_err = ferr_acc_q | ~rx_s;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    if (state_q != S_IDLE && !baud_tc) baud_d = baud_q - 16'd1;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          baud_d  = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            baud_d     = DIV_M1;
            bit_d      = 4'd0;
            par_d      = 1'b0;
            ferr_acc_d = 1'b0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d  = DIV_M1;
          shift_d = {rx_s, shift_q[W-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = 4'd0;
            state_d = (P_UART_CHECK != CHECK_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tc) begin
          baud_d  = DIV_M1;
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          baud_d     = DIV_M1;
          ferr_acc_d = stop_err;
          // Return to IDLE at mid-stop so a start edge at the nominal stop end is seen.
          if (bit_q == LAST_STOP) begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = parity_error(P_UART_CHECK, ^{shift_q, par_q});
            ferr_d  = stop_err;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) | valid_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_q      <= 4'd0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign o_user_rx_data       = data_q;
  assign o_user_rx_valid      = valid_q;
  assign o_user_rx_parity_err = perr_q;
  assign o_user_rx_frame_err  = ferr_q;
  assign o_user_rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances cover no-parity/1-stop,
// even-parity/1-stop and odd-parity/2-stop at DIV = 16.
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;

  // Pin-fall to valid: 2 sync cycles + HALF + (N-1)*DIV + 1
  localparam int LAT_N = 2 + 8 + 9 * 16 + 1;   // 155
  localparam int LAT_E = 2 + 8 + 10 * 16 + 1;  // 171
  localparam int LAT_O = 2 + 8 + 11 * 16 + 1;  // 187

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_n, rx_e, rx_o;
  logic [7:0] data_n, data_e, data_o;
  logic       valid_n, valid_e, valid_o;
  logic       perr_n, perr_e, perr_o;
  logic       ferr_n, ferr_e, ferr_o;
  logic       busy_n, busy_e, busy_o;

  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_n),
    .o_user_rx_data(data_n), .o_user_rx_valid(valid_n),
    .o_user_rx_parity_err(perr_n), .o_user_rx_frame_err(ferr_n),
    .o_user_rx_busy(busy_n));

  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) u_dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_e),
    .o_user_rx_data(data_e), .o_user_rx_valid(valid_e),
    .o_user_rx_parity_err(perr_e), .o_user_rx_frame_err(ferr_e),
    .o_user_rx_busy(busy_e));

  uart_rx #(.P_SYSTEM_CLK(CLK_HZ), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(2), .P_UART_CHECK(1)) u_dut_o (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_o),
    .o_user_rx_data(data_o), .o_user_rx_valid(valid_o),
    .o_user_rx_parity_err(perr_o), .o_user_rx_frame_err(ferr_o),
    .o_user_rx_busy(busy_o));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
    int         cyc;
  } rec_t;

  rec_t q_n[$];
  rec_t q_e[$];
  rec_t q_o[$];

  int cyc = 0;
  int last_fall_cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk_rec(input logic [7:0] d, input logic pe, input logic fe,
                                  input logic b, input int c);
    rec_t r;
    r.data = d; r.perr = pe; r.ferr = fe; r.busy = b; r.cyc = c;
    return r;
  endfunction

  always @(negedge clk) begin
    if (valid_n) q_n.push_back(mk_rec(data_n, perr_n, ferr_n, busy_n, cyc));
    if (valid_e) q_e.push_back(mk_rec(data_e, perr_e, ferr_e, busy_e, cyc));
    if (valid_o) q_o.push_back(mk_rec(data_o, perr_o, ferr_o, busy_o, cyc));
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int sel, input logic v);
    case (sel)
      0:       rx_n = v;
      1:       rx_e = v;
      default: rx_o = v;
    endcase
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic [1:0] stops, input int nstop,
                            input bit jit);
    logic [11:0] bits;
    int n;
    int w;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    n = 9;
    if (has_par) begin
      bits[n] = par;
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[n] = stops[s];
      n++;
    end
    for (int k = 0; k < n; k++) begin
      if (k == 0) last_fall_cyc = cyc;
      drive_line(sel, bits[k]);
      w = jit ? (((k % 2) == 1) ? 17 : 15) : 16;
      repeat (w) @(negedge clk);
    end
  endtask

  function automatic int q_size(input int sel);
    case (sel)
      0:       return q_n.size();
      1:       return q_e.size();
      default: return q_o.size();
    endcase
  endfunction

  task automatic pop_check(input int sel, input string tag, input logic [7:0] d,
                           input logic pe, input logic fe, input int lat);
    rec_t r;
    int sz;
    sz = q_size(sel);
    check_val({tag, "_valid"}, (sz > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sz > 0) begin
      case (sel)
        0:       r = q_n.pop_front();
        1:       r = q_e.pop_front();
        default: r = q_o.pop_front();
      endcase
      check_val({tag, "_data"}, 32'(r.data), 32'(d));
      check_val({tag, "_perr"}, 32'(r.perr), 32'(pe));
      check_val({tag, "_ferr"}, 32'(r.ferr), 32'(fe));
      check_val({tag, "_busy"}, 32'(r.busy), 32'd1);
      if (lat >= 0) check_val({tag, "_lat"}, 32'(r.cyc - last_fall_cyc), 32'(lat));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_n = 1'b1; rx_e = 1'b1; rx_o = 1'b1;
    repeat (5) @(negedge clk);
    check_val("rst_data",  32'(data_n),  32'd0);
    check_val("rst_valid", 32'(valid_n), 32'd0);
    check_val("rst_perr",  32'(perr_n),  32'd0);
    check_val("rst_ferr",  32'(ferr_n),  32'd0);
    check_val("rst_busy",  32'(busy_n),  32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frame
    send_frame(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    repeat (4) @(negedge clk);
    check_val("basic_count", 32'(q_size(0)), 32'd1);
    pop_check(0, "basic", 8'hA5, 1'b0, 1'b0, LAT_N);
    check_val("basic_busy_after", 32'(busy_n), 32'd0);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    send_frame(1, 8'h07, 1'b1, 1'b1, 2'b11, 1, 1'b0);
    repeat (4) @(negedge clk);
    pop_check(1, "par_ok", 8'h07, 1'b0, 1'b0, LAT_E);
    send_frame(1, 8'h07, 1'b1, 1'b0, 2'b11, 1, 1'b0);
    repeat (4) @(negedge clk);
    pop_check(1, "par_bad", 8'h07, 1'b1, 1'b0, LAT_E);

    // Odd parity, 2 stops, second stop low and line left low
    send_frame(2, 8'h12, 1'b1, 1'b1, 2'b01, 2, 1'b0);
    repeat (4) @(negedge clk);
    pop_check(2, "ferr", 8'h12, 1'b0, 1'b1, LAT_O);
    repeat (300) @(negedge clk);
    check_val("low_hold_count", 32'(q_size(2)), 32'd0);
    check_val("low_hold_busy", 32'(busy_o), 32'd0);
    rx_o = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(2, 8'h81, 1'b1, 1'b1, 2'b11, 2, 1'b0);
    repeat (4) @(negedge clk);
    pop_check(2, "recover", 8'h81, 1'b0, 1'b0, LAT_O);

    // Glitch of 3 cycles
    rx_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("g3_busy_t1", 32'(busy_n), 32'd1);
    rx_n = 1'b1;
    repeat (7) @(negedge clk);
    check_val("g3_busy_t8", 32'(busy_n), 32'd1);
    @(negedge clk);
    check_val("g3_busy_t9", 32'(busy_n), 32'd0);
    repeat (20) @(negedge clk);

    // Glitch of 7 cycles
    rx_n = 1'b0;
    repeat (7) @(negedge clk);
    rx_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("g7_busy_t8", 32'(busy_n), 32'd1);
    @(negedge clk);
    check_val("g7_busy_t9", 32'(busy_n), 32'd0);
    repeat (20) @(negedge clk);
    check_val("glitch_count", 32'(q_size(0)), 32'd0);

    send_frame(0, 8'h3C, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    repeat (4) @(negedge clk);
    pop_check(0, "after_glitch", 8'h3C, 1'b0, 1'b0, LAT_N);

    // Back-to-back with +/-1 cycle jitter
    send_frame(0, 8'h00, 1'b0, 1'b0, 2'b11, 1, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 2'b11, 1, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b0, 2'b11, 1, 1'b1);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 2'b11, 1, 1'b1);
    repeat (10) @(negedge clk);
    check_val("b2b_count", 32'(q_size(0)), 32'd4);
    pop_check(0, "b2b0", 8'h00, 1'b0, 1'b0, -1);
    pop_check(0, "b2b1", 8'hFF, 1'b0, 1'b0, -1);
    pop_check(0, "b2b2", 8'h55, 1'b0, 1'b0, -1);
    pop_check(0, "b2b3", 8'hAA, 1'b0, 1'b0, -1);

    // Reset during data bit 3 of 0x5B (bits 1,1,0,1,...)
    repeat (10) @(negedge clk);
    rx_n = 1'b0;
    repeat (16) @(negedge clk);
    rx_n = 1'b1; repeat (16) @(negedge clk);
    rx_n = 1'b1; repeat (16) @(negedge clk);
    rx_n = 1'b0; repeat (16) @(negedge clk);
    rx_n = 1'b1; repeat (8) @(negedge clk);
    check_val("midrst_busy_pre", 32'(busy_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_data",  32'(data_n),  32'd0);
    check_val("midrst_valid", 32'(valid_n), 32'd0);
    check_val("midrst_perr",  32'(perr_n),  32'd0);
    check_val("midrst_ferr",  32'(ferr_n),  32'd0);
    check_val("midrst_busy",  32'(busy_n),  32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check_val("midrst_count", 32'(q_size(0)), 32'd0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    repeat (4) @(negedge clk);
    pop_check(0, "post_rst", 8'h81, 1'b0, 1'b0, LAT_N);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
